// File: rtl/chacha_pkg.sv
// Shared definitions for the keystream sequencing slice: controller states and
// default geometry of one buffer fill.
package chacha_pkg;

  localparam int CTR_W_DEF            = 32;
  localparam int BYTES_PER_MATRIX_DEF = 64;
  localparam int NUM_MATRICES_DEF     = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_GEN       = 3'd2,
    ST_SER       = 3'd3,
    ST_WAIT_FULL = 3'd4,
    ST_HANDOFF   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/seq_byte_counter.sv
// Counts serialised bytes of one state matrix; o_tc flags the final byte slot.
module seq_byte_counter #(
  parameter int BYTES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0] LAST = BW'(BYTES - 1);

  logic [BW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + BW'(1);
    end
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/keystream_seq_ctrl.sv
// Sequences ChaCha20 block generation, serialisation and buffer handoff for a
// run of num_fills buffers, each holding NUM_MATRICES state matrices.
module keystream_seq_ctrl
  import chacha_pkg::*;
#(
  parameter int NUM_MATRICES     = NUM_MATRICES_DEF,
  parameter int BYTES_PER_MATRIX = BYTES_PER_MATRIX_DEF,
  parameter int CTR_W            = CTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CTR_W-1:0] init_ctr,
  input  logic [15:0]      num_fills,
  input  logic             abort,
  output logic             core_start,
  output logic [CTR_W-1:0] core_ctr,
  input  logic             core_done,
  output logic             ser_en,
  input  logic             ser_valid,
  output logic             concat_en,
  output logic             concat_rst,
  input  logic             concat_full,
  output logic             buf_valid,
  input  logic             buf_ready,
  output logic             busy,
  output logic             ctr_wrap_err
);

  localparam int MW = $clog2(NUM_MATRICES + 1);
  localparam logic [MW-1:0] MAT_LAST = MW'(NUM_MATRICES - 1);

  seq_state_t       r_state;
  logic [CTR_W-1:0] r_ctr;
  logic [15:0]      r_fills;
  logic [MW-1:0]    r_mcnt;
  logic             r_core_start;
  logic             r_ser_en;
  logic             r_concat_en;
  logic             r_concat_rst;
  logic             r_buf_valid;
  logic             r_wrap;

  logic w_in_ser;
  logic w_byte_tc;
  logic w_last_byte;

  assign w_in_ser    = (r_state == ST_SER);
  assign w_last_byte = w_in_ser && ser_valid && w_byte_tc;

  seq_byte_counter #(
    .BYTES(BYTES_PER_MATRIX)
  ) u_byte_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(!w_in_ser || abort),
    .i_inc(w_in_ser && ser_valid),
    .o_tc (w_byte_tc)
  );

  // Outputs are registered alongside the state they belong to, so every
  // enable/pulse is set on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ctr        <= '0;
      r_fills      <= '0;
      r_mcnt       <= '0;
      r_wrap       <= 1'b0;
      r_core_start <= 1'b0;
      r_ser_en     <= 1'b0;
      r_concat_en  <= 1'b0;
      r_buf_valid  <= 1'b0;
      r_concat_rst <= 1'b1;
    end else begin
      r_core_start <= 1'b0;
      r_concat_rst <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state      <= ST_IDLE;
        r_ser_en     <= 1'b0;
        r_concat_en  <= 1'b0;
        r_buf_valid  <= 1'b0;
        r_concat_rst <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_ctr        <= init_ctr;
              r_fills      <= (num_fills == 16'd0) ? 16'd1 : num_fills;
              r_mcnt       <= '0;
              r_wrap       <= 1'b0;
              r_concat_rst <= 1'b1;
              r_state      <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            r_core_start <= 1'b1;
            r_state      <= ST_GEN;
          end
          ST_GEN: begin
            if (core_done) begin
              r_ser_en    <= 1'b1;
              r_concat_en <= 1'b1;
              r_state     <= ST_SER;
            end
          end
          ST_SER: begin
            if (w_last_byte) begin
              r_ctr       <= r_ctr + CTR_W'(1);
              r_mcnt      <= r_mcnt + MW'(1);
              r_ser_en    <= 1'b0;
              r_concat_en <= 1'b0;
              if (r_ctr == '1) begin
                r_wrap  <= 1'b1;
                r_state <= ST_IDLE;
              end else if (r_mcnt != MAT_LAST) begin
                r_core_start <= 1'b1;
                r_state      <= ST_GEN;
              end else begin
                r_state <= ST_WAIT_FULL;
              end
            end
          end
          ST_WAIT_FULL: begin
            if (concat_full) begin
              r_buf_valid <= 1'b1;
              r_state     <= ST_HANDOFF;
            end
          end
          ST_HANDOFF: begin
            if (buf_ready) begin
              r_buf_valid <= 1'b0;
              r_fills     <= r_fills - 16'd1;
              if (r_fills == 16'd1) begin
                r_state <= ST_IDLE;
              end else begin
                r_mcnt       <= '0;
                r_concat_rst <= 1'b1;
                r_state      <= ST_CLEAR;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign core_start   = r_core_start;
  assign core_ctr     = r_ctr;
  assign ser_en       = r_ser_en;
  assign concat_en    = r_concat_en;
  assign concat_rst   = r_concat_rst;
  assign buf_valid    = r_buf_valid;
  assign busy         = (r_state != ST_IDLE);
  assign ctr_wrap_err = r_wrap;

endmodule

// File: tb/tb_keystream_seq_ctrl.sv
// Bench for keystream_seq_ctrl: reactive core/serialiser/concatenator/sink
// models, a cycle-level behavioural reference, and directed + random runs.
module tb_keystream_seq_ctrl;

  localparam int NM  = 2;
  localparam int BPM = 64;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] init_ctr = '0;
  logic [15:0]   num_fills = '0;
  logic          abort = 1'b0;
  logic          core_start;
  logic [CW-1:0] core_ctr;
  logic          core_done = 1'b0;
  logic          ser_en;
  logic          ser_valid = 1'b0;
  logic          concat_en;
  logic          concat_rst;
  logic          concat_full = 1'b0;
  logic          buf_valid;
  logic          buf_ready = 1'b0;
  logic          busy;
  logic          ctr_wrap_err;

  keystream_seq_ctrl #(
    .NUM_MATRICES    (NM),
    .BYTES_PER_MATRIX(BPM),
    .CTR_W           (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .init_ctr    (init_ctr),
    .num_fills   (num_fills),
    .abort       (abort),
    .core_start  (core_start),
    .core_ctr    (core_ctr),
    .core_done   (core_done),
    .ser_en      (ser_en),
    .ser_valid   (ser_valid),
    .concat_en   (concat_en),
    .concat_rst  (concat_rst),
    .concat_full (concat_full),
    .buf_valid   (buf_valid),
    .buf_ready   (buf_ready),
    .busy        (busy),
    .ctr_wrap_err(ctr_wrap_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, got, exp);
    end
  endtask

  // Environment knobs
  int core_lat = 10;
  int ser_pct = 100;
  int base_delay = 0;
  int stall_at = -1;
  int stall_len = 0;
  bit spurious = 1'b0;

  // Environment state
  int core_cd = 0;
  int rdy_cnt = 0;
  int ccnt = 0;
  int n_xfer = 0;
  int cs_in_offer = 0;
  logic [CW-1:0] ctr_log[$];

  // Reference model state: what the controller is doing at the moment
  bit m_clear = 0, m_gen = 0, m_ser = 0, m_waitf = 0, m_offer = 0;
  bit m_cstart = 0, m_crst = 0, m_wrap = 0;
  int m_bytes = 0, m_mat = 0, m_fills = 0;
  logic [CW-1:0] m_ctr = '0;

  function automatic logic [CW-1:0] get_ctr(input int i);
    if (i < ctr_log.size()) return ctr_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin : model
    bit cl, gn, sr, wf, of, cs, cr, wr, act, wrapped;
    int nb, nm, nf;
    logic [CW-1:0] ct;
    cl = m_clear; gn = m_gen; sr = m_ser; wf = m_waitf; of = m_offer;
    wr = m_wrap; nb = m_bytes; nm = m_mat; nf = m_fills; ct = m_ctr;
    act = cl | gn | sr | wf | of;
    cs = 1'b0; cr = 1'b0;
    if (rst) begin
      {cl, gn, sr, wf, of, wr} = '0;
      cr = 1'b1; nb = 0; nm = 0; nf = 0; ct = '0;
    end else if (act && abort) begin
      {cl, gn, sr, wf, of} = '0;
      cr = 1'b1;
    end else if (!act) begin
      if (start && !abort) begin
        ct = init_ctr;
        nf = (num_fills == 16'd0) ? 1 : int'(num_fills);
        nm = 0; wr = 1'b0; cl = 1'b1; cr = 1'b1;
      end
    end else if (cl) begin
      cl = 1'b0; gn = 1'b1; cs = 1'b1;
    end else if (gn) begin
      if (core_done) begin gn = 1'b0; sr = 1'b1; nb = 0; end
    end else if (sr) begin
      if (ser_valid) begin
        nb++;
        if (nb == BPM) begin
          sr = 1'b0; nb = 0; nm++;
          wrapped = (ct == {CW{1'b1}});
          ct = ct + 1'b1;
          if (wrapped) wr = 1'b1;
          else if (nm < NM) begin gn = 1'b1; cs = 1'b1; end
          else wf = 1'b1;
        end
      end
    end else if (wf) begin
      if (concat_full) begin wf = 1'b0; of = 1'b1; end
    end else if (of) begin
      if (buf_ready) begin
        of = 1'b0; nf--;
        if (nf > 0) begin cl = 1'b1; cr = 1'b1; nm = 0; end
      end
    end
    m_clear <= cl; m_gen <= gn; m_ser <= sr; m_waitf <= wf; m_offer <= of;
    m_cstart <= cs; m_crst <= cr; m_wrap <= wr;
    m_bytes <= nb; m_mat <= nm; m_fills <= nf; m_ctr <= ct;
    // concatenator occupancy and completed handoffs, from pre-edge DUT outputs
    if (concat_rst === 1'b1) ccnt <= 0;
    else if (concat_en === 1'b1 && ser_valid) ccnt <= ccnt + 1;
    if (!rst && buf_valid === 1'b1 && buf_ready) n_xfer <= n_xfer + 1;
  end

  always @(negedge clk) begin : env
    int cd;
    int dly;
    bit dn;
    cd = core_cd; dn = 1'b0;
    if (cd > 0) begin cd--; if (cd == 0) dn = 1'b1; end
    if (core_start === 1'b1) cd = core_lat;
    if (spurious && $urandom_range(99) < 2) dn = 1'b1;
    core_cd   <= cd;
    core_done <= dn;
    ser_valid <= ($urandom_range(99) < ser_pct);
    concat_full <= (ccnt >= NM * BPM);
    if (buf_valid === 1'b1) begin
      dly = (n_xfer == stall_at) ? stall_len : base_delay;
      buf_ready <= (rdy_cnt >= dly);
      rdy_cnt   <= rdy_cnt + 1;
    end else begin
      buf_ready <= ($urandom_range(1) == 1);
      rdy_cnt   <= 0;
    end
  end

  always @(negedge clk) begin : compare
    bit prev_bv;
    if (core_start === 1'b1) ctr_log.push_back(core_ctr);
    if (buf_valid === 1'b1 && core_start === 1'b1) cs_in_offer <= cs_in_offer + 1;
    if (chk_en) begin
      chk("core_start", core_start, m_cstart);
      chk("core_ctr", core_ctr, m_ctr);
      chk("ser_en", ser_en, m_ser);
      chk("concat_en", concat_en, m_ser);
      chk("concat_rst", concat_rst, m_crst);
      chk("buf_valid", buf_valid, m_offer);
      chk("busy", busy, m_clear | m_gen | m_ser | m_waitf | m_offer);
      chk("ctr_wrap_err", ctr_wrap_err, m_wrap);
      if (buf_valid === 1'b1 && !prev_bv) chk("full_bytes", ccnt, NM * BPM);
    end
    prev_bv = (buf_valid === 1'b1);
  end

  task automatic go(input logic [CW-1:0] ic, input logic [15:0] nf);
    init_ctr  = ic;
    num_fills = nf;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (n >= limit), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, cs0, n;
    repeat (3) @(negedge clk);
    chk("rst_concat_rst", concat_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_buf_valid", buf_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_ser_en", ser_en, 0);
    chk("rst_core_ctr", core_ctr, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_concat_rst", concat_rst, 0);

    // One fill from counter 5 with fixed core latency and back-to-back bytes
    ctr_log.delete(); x0 = n_xfer;
    go(32'd5, 16'd1);
    wait_idle("t1_timeout", 3000);
    chk("t1_nblocks", ctr_log.size(), 2);
    chk("t1_ctr0", get_ctr(0), 5);
    chk("t1_ctr1", get_ctr(1), 6);
    chk("t1_buffers", n_xfer - x0, 1);
    chk("t1_wrap", ctr_wrap_err, 0);

    // Three fills; sink stalls 20 cycles on the second one
    ctr_log.delete(); x0 = n_xfer; cs0 = cs_in_offer;
    stall_at = x0 + 1; stall_len = 20;
    go(32'd0, 16'd3);
    wait_idle("t2_timeout", 5000);
    chk("t2_nblocks", ctr_log.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_ctr%0d", i), get_ctr(i), i);
    chk("t2_buffers", n_xfer - x0, 3);
    chk("t2_core_start_in_stall", cs_in_offer - cs0, 0);
    stall_at = -1;

    // Counter at all-ones: wrap error after the first matrix, no handoff
    ctr_log.delete(); x0 = n_xfer;
    go(32'hFFFF_FFFF, 16'd2);
    wait_idle("t3_timeout", 3000);
    chk("t3_wrap", ctr_wrap_err, 1);
    chk("t3_buffers", n_xfer - x0, 0);
    chk("t3_nblocks", ctr_log.size(), 1);
    chk("t3_ctr0", get_ctr(0), 32'hFFFF_FFFF);
    chk("t3_ctr_after", core_ctr, 0);

    // Abort after 30 bytes of the first matrix, then a clean run
    go(32'd100, 16'd1);
    n = 0;
    while (ccnt != 30 && n < 2000) begin @(negedge clk); n++; end
    chk("t4_reach_byte30", (n >= 2000), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_concat_rst", concat_rst, 1);
    chk("t4_ser_en", ser_en, 0);
    chk("t4_concat_en", concat_en, 0);
    @(negedge clk);
    chk("t4_concat_rst_pulse", concat_rst, 0);
    ctr_log.delete(); x0 = n_xfer;
    go(32'd200, 16'd1);
    wait_idle("t4_timeout", 3000);
    chk("t4_restart_buffers", n_xfer - x0, 1);
    chk("t4_restart_ctr0", get_ctr(0), 200);
    chk("t4_restart_ctr1", get_ctr(1), 201);

    // Gapped serialiser, random core latency
    ser_pct = 50; core_lat = $urandom_range(1, 12);
    x0 = n_xfer;
    go($urandom & 32'h7FFF_FFFF, 16'd2);
    wait_idle("t5_timeout", 20000);
    chk("t5_buffers", n_xfer - x0, 2);

    // Reset while the buffer is being offered
    ser_pct = 100; base_delay = 1000;
    go(32'd7, 16'd1);
    n = 0;
    while (buf_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk("t6_reach_handoff", (n >= 3000), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_buf_valid", buf_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_core_start", core_start, 0);
    chk("t6_ser_en", ser_en, 0);
    chk("t6_concat_en", concat_en, 0);
    chk("t6_concat_rst", concat_rst, 1);
    chk("t6_core_ctr", core_ctr, 0);
    rst = 1'b0;
    base_delay = 0;
    repeat (40) @(negedge clk);

    // Random runs with stray pulses, aborts and ignored starts
    spurious = 1'b1;
    for (int r = 0; r < 8; r++) begin
      logic [CW-1:0] ic;
      core_lat   = $urandom_range(1, 12);
      ser_pct    = $urandom_range(30, 100);
      base_delay = $urandom_range(0, 5);
      ic = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 2)) : $urandom;
      abort = ($urandom_range(9) == 0);
      go(ic, 16'($urandom_range(0, 3)));
      abort = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 15000) begin
        abort     = ($urandom_range(399) == 0);
        start     = ($urandom_range(19) == 0);
        init_ctr  = $urandom;
        num_fills = 16'($urandom_range(0, 2));
        @(negedge clk);
        n++;
      end
      abort = 1'b0;
      start = 1'b0;
      chk("rand_timeout", (n >= 15000), 0);
      repeat (3) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
